// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin arbiter and sequencer for one shared ALU.
// One operation in flight at a time; operands latched, result and flags registered.
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2:0]       req0_op,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [2:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_rega,
  output logic [WIDTH-1:0] alu_regb,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_unsupported(input logic [2:0] op);
    return (op[2:1] == 2'b11);
  endfunction

  function automatic logic [1:0] onehot2(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

  state_t           state_r;
  state_t           state_next_s;
  logic             prio_r;
  logic             owner_r;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             err_r;
  logic [1:0]       rsp_valid_r;

  logic             grant_valid_s;
  logic             grant_id_s;
  logic [1:0]       req_ready_s;
  logic             accept_s;
  logic             rsp_done_s;

  // Round-robin grant: a lone requester wins, a tie goes to prio.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = 1'b0;
    case (req_valid)
      2'b01: begin
        grant_valid_s = 1'b1;
        grant_id_s    = 1'b0;
      end
      2'b10: begin
        grant_valid_s = 1'b1;
        grant_id_s    = 1'b1;
      end
      2'b11: begin
        grant_valid_s = 1'b1;
        grant_id_s    = prio_r;
      end
      default: begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
      end
    endcase
  end

  // Request accept is only offered in IDLE, and only to the granted requester.
  always_comb begin
    req_ready_s = 2'b00;
    if ((state_r == IDLE) && grant_valid_s) begin
      req_ready_s = onehot2(grant_id_s);
    end else begin
      req_ready_s = 2'b00;
    end
  end

  assign accept_s   = |(req_valid & req_ready_s);
  assign rsp_done_s = (state_r == RESP) && rsp_ready[owner_r];

  // Next-state logic for the accept / execute / respond sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = EXEC;
        end else begin
          state_next_s = IDLE;
        end
      end
      EXEC: begin
        state_next_s = RESP;
      end
      RESP: begin
        if (rsp_done_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand capture and round-robin pointer update on an accepted request.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      prio_r  <= 1'b0;
      owner_r <= 1'b0;
      op_r    <= 3'b000;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      prio_r  <= ~grant_id_s;
      owner_r <= grant_id_s;
      op_r    <= grant_id_s ? req1_op : req0_op;
      a_r     <= grant_id_s ? req1_a  : req0_a;
      b_r     <= grant_id_s ? req1_b  : req0_b;
    end else begin
      prio_r  <= prio_r;
      owner_r <= owner_r;
      op_r    <= op_r;
      a_r     <= a_r;
      b_r     <= b_r;
    end
  end

  // Response registers: capture ALU output at the end of EXEC, hold through RESP.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      result_r    <= {WIDTH{1'b0}};
      zero_r      <= 1'b0;
      err_r       <= 1'b0;
      rsp_valid_r <= 2'b00;
    end else if (state_r == EXEC) begin
      // Unsupported opcodes report a clean zero result whatever the ALU drives.
      if (is_unsupported(op_r)) begin
        result_r <= {WIDTH{1'b0}};
        zero_r   <= 1'b1;
        err_r    <= 1'b1;
      end else begin
        result_r <= alu_result;
        zero_r   <= alu_zero;
        err_r    <= 1'b0;
      end
      rsp_valid_r <= onehot2(owner_r);
    end else if (rsp_done_s) begin
      result_r    <= result_r;
      zero_r      <= zero_r;
      err_r       <= err_r;
      rsp_valid_r <= 2'b00;
    end else begin
      result_r    <= result_r;
      zero_r      <= zero_r;
      err_r       <= err_r;
      rsp_valid_r <= rsp_valid_r;
    end
  end

  assign req_ready  = req_ready_s;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_result = result_r;
  assign rsp_zero   = zero_r;
  assign rsp_err    = err_r;
  assign alu_opcode = op_r;
  assign alu_rega   = a_r;
  assign alu_regb   = b_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed testbench for alu_share_arbiter; the bench also plays the role of the ALU.
module tb_alu_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [2:0]  req0_op;
  logic [2:0]  req1_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_err;
  logic [2:0]  alu_opcode;
  logic [31:0] alu_rega;
  logic [31:0] alu_regb;
  logic [31:0] alu_result;
  logic        alu_zero;

  int n_vectors;
  int n_miscompares;

  alu_share_arbiter #(.WIDTH(32)) dut (
    .CLK        (clk),
    .RST_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req0_op    (req0_op),
    .req1_op    (req1_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err),
    .alu_opcode (alu_opcode),
    .alu_rega   (alu_rega),
    .alu_regb   (alu_regb),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stand-in; unsupported opcodes drive junk so masking is observable.
  always_comb begin
    case (alu_opcode)
      3'b000:  alu_result = alu_rega + alu_regb;
      3'b001:  alu_result = alu_rega - alu_regb;
      3'b010:  alu_result = alu_rega & alu_regb;
      3'b011:  alu_result = alu_rega | alu_regb;
      3'b100:  alu_result = alu_rega ^ alu_regb;
      3'b101:  alu_result = ($signed(alu_rega) < $signed(alu_regb)) ? 32'd1 : 32'd0;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One full transaction; returns at the negedge of the final RESP cycle.
  task automatic run_op(input logic [1:0] valid, input logic owner,
                        input logic [2:0] exp_op, input logic [31:0] exp_a,
                        input logic [31:0] exp_b, input logic [31:0] exp_res,
                        input logic exp_zero, input logic exp_err, input int stall);
    logic [1:0] oh;
    oh = owner ? 2'b10 : 2'b01;
    @(negedge clk);
    req_valid = valid;
    #1 check_val("req_ready_grant", {30'd0, req_ready}, {30'd0, oh});
    @(negedge clk);
    req_valid = 2'b00;
    rsp_ready = (stall > 0) ? 2'b00 : 2'b11;
    #1;
    check_val("exec_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check_val("exec_req_ready", {30'd0, req_ready}, 32'd0);
    check_val("exec_alu_opcode", {29'd0, alu_opcode}, {29'd0, exp_op});
    check_val("exec_alu_rega", alu_rega, exp_a);
    check_val("exec_alu_regb", alu_regb, exp_b);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      req_valid = valid;
      rsp_ready = owner ? 2'b01 : 2'b10;
      #1;
      check_val("stall_rsp_valid", {30'd0, rsp_valid}, {30'd0, oh});
      check_val("stall_req_ready", {30'd0, req_ready}, 32'd0);
      check_val("stall_result", rsp_result, exp_res);
      check_val("stall_alu_rega", alu_rega, exp_a);
    end
    @(negedge clk);
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    #1;
    check_val("rsp_valid", {30'd0, rsp_valid}, {30'd0, oh});
    check_val("rsp_result", rsp_result, exp_res);
    check_val("rsp_zero", {31'd0, rsp_zero}, {31'd0, exp_zero});
    check_val("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
    check_val("rsp_alu_opcode", {29'd0, alu_opcode}, {29'd0, exp_op});
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_req_ready"}, {30'd0, req_ready}, 32'd0);
    check_val({tag, "_rsp_valid"}, {30'd0, rsp_valid}, 32'd0);
    check_val({tag, "_rsp_result"}, rsp_result, 32'd0);
    check_val({tag, "_rsp_zero"}, {31'd0, rsp_zero}, 32'd0);
    check_val({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
    check_val({tag, "_alu_opcode"}, {29'd0, alu_opcode}, 32'd0);
    check_val({tag, "_alu_rega"}, alu_rega, 32'd0);
    check_val({tag, "_alu_regb"}, alu_regb, 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    #1 check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_vectors     = 0;
    n_miscompares = 0;
    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req0_op = 3'b000; req0_a = 32'd0; req0_b = 32'd0;
    req1_op = 3'b000; req1_a = 32'd0; req1_b = 32'd0;
    #12;
    apply_reset();

    // Single request from req0: 5 + 7.
    req0_op = 3'b000; req0_a = 32'd5; req0_b = 32'd7;
    run_op(2'b01, 1'b0, 3'b000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 0);
    // prio is now 1: a tie grants req1.
    @(negedge clk);
    req_valid = 2'b11;
    #1 check_val("tie_after_req0", {30'd0, req_ready}, 32'd2);
    req_valid = 2'b00;

    // Simultaneous requests after reset: req0 first, then req1, then req0 again.
    apply_reset();
    req0_op = 3'b001; req0_a = 32'd3;    req0_b = 32'd3;
    req1_op = 3'b011; req1_a = 32'hF0;   req1_b = 32'h0F;
    run_op(2'b11, 1'b0, 3'b001, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0, 0);
    run_op(2'b10, 1'b1, 3'b011, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0, 0);
    run_op(2'b11, 1'b0, 3'b001, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0, 0);

    // Back-pressure: req1 signed compare held for 4 cycles.
    req1_op = 3'b101; req1_a = 32'hFFFF_FFFF; req1_b = 32'd1;
    run_op(2'b10, 1'b1, 3'b101, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 4);

    // Unsupported opcode, then a normal op.
    req0_op = 3'b111; req0_a = 32'd1; req0_b = 32'd2;
    run_op(2'b01, 1'b0, 3'b111, 32'd1, 32'd2, 32'd0, 1'b1, 1'b1, 0);
    req0_op = 3'b010; req0_a = 32'd6; req0_b = 32'd3;
    run_op(2'b01, 1'b0, 3'b010, 32'd6, 32'd3, 32'd2, 1'b0, 1'b0, 0);

    // Reset during EXEC of req0 (prio would be 1 if not cleared).
    req0_op = 3'b000; req0_a = 32'd9; req0_b = 32'd4;
    @(negedge clk);
    req_valid = 2'b01;
    rsp_ready = 2'b11;
    @(negedge clk);
    req_valid = 2'b00;
    #1 check_val("pre_reset_alu_rega", alu_rega, 32'd9);
    rst_n = 1'b0;
    #1 check_all_zero("midreset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check_val("midreset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    #1 check_val("post_reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    req_valid = 2'b11;
    #1 check_val("post_reset_grant", {30'd0, req_ready}, 32'd1);
    req_valid = 2'b00;

    // Continuous req0 traffic with rsp_ready high: one accept every 3 cycles.
    for (int k = 0; k < 4; k++) begin
      req0_op = 3'b000; req0_a = 32'd100 * k; req0_b = 32'd1;
      run_op(2'b01, 1'b0, 3'b000, 32'd100 * k, 32'd1, 32'd100 * k + 32'd1, 1'b0, 1'b0, 0);
    end
    @(negedge clk);
    #1 check_val("final_rsp_valid", {30'd0, rsp_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
